z8_debug_dump: RTL and testbench

- Hardware snapshot/dump engine for the z8ProcessorCore. Triggered by a core halt or an explicit start, it serialises register-file contents, data memory, flags and stack pointer onto a valid/ready record stream.
- Replaces bench-side hierarchical peeking with a synthesizable, parametrised dump path that feeds a UART/JTAG/trace sink.
- Sits beside the core and shares its register-file and data-memory debug read ports.

---
 rtl/z8_debug_dump.sv | 172 +++++++++++++++++
 tb/tb_z8_debug_dump.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/z8_debug_dump.sv
// Snapshot/dump engine for the z8 core: streams registers, data memory, flags and SP
// as valid/ready records, triggered by start or a rising edge of halted.
module z8_debug_dump #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 8,
  parameter int NUM_REGS     = 4,
  parameter int MEM_WORDS    = 256,
  parameter int ROW_WORDS    = 16,
  parameter int AUTO_ON_HALT = 1,
  localparam int RIDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halted,
  input  logic [3:0]        flags_in,
  input  logic [ADDR_W-1:0] stack_ptr,
  output logic [RIDX_W-1:0] reg_rd_addr,
  input  logic [DATA_W-1:0] reg_rd_data,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_kind,
  output logic [ADDR_W-1:0] out_tag,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sp_mark,
  output logic              out_row_end,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int MAXN  = (MEM_WORDS > NUM_REGS) ? MEM_WORDS : NUM_REGS;
  localparam int IDX_W = $clog2(MAXN + 1);
  localparam int CW    = (IDX_W > ADDR_W) ? IDX_W : ADDR_W;
  localparam logic [IDX_W-1:0] ROW_MASK = IDX_W'(ROW_WORDS - 1);
  localparam logic [IDX_W-1:0] LAST_REG = IDX_W'(NUM_REGS - 1);
  localparam logic [IDX_W-1:0] LAST_MEM = IDX_W'(MEM_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE, REG_FETCH, MEM_FETCH, MEM_WAIT, SEND, FIN
  } state_e;

  typedef enum logic [1:0] {
    K_REG = 2'd0, K_MEM = 2'd1, K_FLAGS = 2'd2, K_SP = 2'd3
  } kind_e;

  state_e             state_q;
  kind_e              kind_q;
  logic [IDX_W-1:0]   idx_q;
  logic               halted_q;
  logic [3:0]         flags_q;
  logic [ADDR_W-1:0]  sp_q;
  logic               valid_q, mark_q, row_end_q, last_q, done_q;
  logic [ADDR_W-1:0]  tag_q;
  logic [DATA_W-1:0]  data_q;
  logic               trig;

  assign trig = start || ((AUTO_ON_HALT != 0) && halted && !halted_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      kind_q    <= K_REG;
      idx_q     <= '0;
      halted_q  <= halted;
      flags_q   <= '0;
      sp_q      <= '0;
      valid_q   <= 1'b0;
      mark_q    <= 1'b0;
      row_end_q <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      tag_q     <= '0;
      data_q    <= '0;
    end else begin
      halted_q <= halted;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (trig) begin
            flags_q <= flags_in;
            sp_q    <= stack_ptr;
            idx_q   <= '0;
            state_q <= REG_FETCH;
          end
        end
        REG_FETCH: begin
          kind_q    <= K_REG;
          tag_q     <= ADDR_W'(idx_q);
          data_q    <= reg_rd_data;
          mark_q    <= 1'b0;
          row_end_q <= 1'b0;
          last_q    <= 1'b0;
          valid_q   <= 1'b1;
          state_q   <= SEND;
        end
        MEM_FETCH: state_q <= MEM_WAIT;
        MEM_WAIT: begin
          kind_q    <= K_MEM;
          tag_q     <= ADDR_W'(idx_q);
          data_q    <= mem_rd_data;
          mark_q    <= (CW'(sp_q) == CW'(idx_q));
          row_end_q <= ((idx_q & ROW_MASK) == ROW_MASK);
          last_q    <= 1'b0;
          valid_q   <= 1'b1;
          state_q   <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            // FLAGS and SP follow back-to-back from the snapshot with valid held high
            case (kind_q)
              K_REG: begin
                valid_q <= 1'b0;
                if (idx_q == LAST_REG) begin
                  idx_q   <= '0;
                  state_q <= MEM_FETCH;
                end else begin
                  idx_q   <= idx_q + IDX_W'(1);
                  state_q <= REG_FETCH;
                end
              end
              K_MEM: begin
                if (idx_q == LAST_MEM) begin
                  kind_q    <= K_FLAGS;
                  tag_q     <= '0;
                  data_q    <= DATA_W'(flags_q);
                  mark_q    <= 1'b0;
                  row_end_q <= 1'b0;
                end else begin
                  valid_q <= 1'b0;
                  idx_q   <= idx_q + IDX_W'(1);
                  state_q <= MEM_FETCH;
                end
              end
              K_FLAGS: begin
                kind_q <= K_SP;
                tag_q  <= '0;
                data_q <= DATA_W'(sp_q);
                last_q <= 1'b1;
              end
              default: begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= FIN;
              end
            endcase
          end
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign reg_rd_addr = idx_q[RIDX_W-1:0];
  assign mem_rd_en   = (state_q == MEM_FETCH);
  assign mem_rd_addr = ADDR_W'(idx_q);
  assign out_valid   = valid_q;
  assign out_kind    = kind_q;
  assign out_tag     = tag_q;
  assign out_data    = data_q;
  assign out_sp_mark = mark_q;
  assign out_row_end = row_end_q;
  assign out_last    = last_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;

endmodule

// File: tb/tb_z8_debug_dump.sv
// Directed bench for z8_debug_dump: table of dump scenarios checked record-by-record
// against a reference model, plus hand-written reset/retrigger sequences.
module tb_z8_debug_dump;

  logic        clk = 1'b0;
  logic        reset, start, halted, out_ready;
  logic [3:0]  flags_in;
  logic [7:0]  stack_ptr;
  logic [1:0]  reg_rd_addr;
  logic [15:0] reg_rd_data, mem_rd_data;
  logic        mem_rd_en;
  logic [7:0]  mem_rd_addr;
  logic        out_valid, out_sp_mark, out_row_end, out_last, busy, done;
  logic [1:0]  out_kind;
  logic [7:0]  out_tag;
  logic [15:0] out_data;

  logic [15:0] regs [4];
  logic [15:0] mem  [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  z8_debug_dump #(.DATA_W(16), .ADDR_W(8), .NUM_REGS(4), .MEM_WORDS(256),
                  .ROW_WORDS(16), .AUTO_ON_HALT(1)) dut (
    .clk(clk), .reset(reset), .start(start), .halted(halted),
    .flags_in(flags_in), .stack_ptr(stack_ptr),
    .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
    .out_tag(out_tag), .out_data(out_data), .out_sp_mark(out_sp_mark),
    .out_row_end(out_row_end), .out_last(out_last), .busy(busy), .done(done)
  );

  assign reg_rd_data = regs[reg_rd_addr];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected record n as {kind, tag, data, sp_mark, row_end, last}
  logic [7:0] exp_sp;
  logic [3:0] exp_flags;
  function automatic logic [28:0] exp_rec(input int n);
    logic [7:0] a;
    if (n < 4)        return {2'd0, 8'(n), regs[n], 3'b000};
    else if (n < 260) begin
      a = 8'(n - 4);
      return {2'd1, a, mem[a], (a == exp_sp), (a[3:0] == 4'hF), 1'b0};
    end
    else if (n == 260) return {2'd2, 8'h00, 12'h000, exp_flags, 3'b000};
    else               return {2'd3, 8'h00, 8'h00, exp_sp, 3'b001};
  endfunction

  // Negedge monitor: per-handshake record check and hold-stability check
  logic        mon_en = 1'b0;
  logic        hold_pending = 1'b0;
  logic [28:0] held;
  int rec_cnt, done_cnt, rowend_cnt, mark_cnt;
  wire  [28:0] cur = {out_kind, out_tag, out_data, out_sp_mark, out_row_end, out_last};

  always @(negedge clk) begin
    if (mon_en) begin
      if (hold_pending) check("hold_stable", {2'b0, out_valid, cur}, {2'b0, 1'b1, held});
      if (out_valid && out_ready) begin
        check($sformatf("rec%0d", rec_cnt), {3'b0, cur}, {3'b0, exp_rec(rec_cnt)});
        rec_cnt++;
        if (out_row_end) rowend_cnt++;
        if (out_sp_mark) mark_cnt++;
        hold_pending = 1'b0;
      end else if (out_valid) begin
        hold_pending = 1'b1;
        held = cur;
      end else hold_pending = 1'b0;
      if (done) done_cnt++;
    end
  end

  typedef struct {
    logic       use_start;
    logic       rnd_ready;
    logic       disturb;
    logic [7:0] sp;
    logic [3:0] flags;
  } vec_t;
  vec_t vecs [4];

  initial begin
    vecs[0] = '{use_start: 1'b0, rnd_ready: 1'b0, disturb: 1'b0, sp: 8'hFD, flags: 4'h0};
    vecs[1] = '{use_start: 1'b0, rnd_ready: 1'b1, disturb: 1'b1, sp: 8'hFD, flags: 4'hA};
    vecs[2] = '{use_start: 1'b1, rnd_ready: 1'b1, disturb: 1'b1, sp: 8'h00, flags: 4'hF};
    vecs[3] = '{use_start: 1'b1, rnd_ready: 1'b0, disturb: 1'b0, sp: 8'hFF, flags: 4'h5};

    regs[0] = 16'd1; regs[1] = 16'd2; regs[2] = 16'd0; regs[3] = 16'd0;
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 3);

    reset = 1'b1; start = 1'b0; halted = 1'b0; out_ready = 1'b1;
    flags_in = 4'h0; stack_ptr = 8'hFD;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_memen", 32'(mem_rd_en), 32'd0);
    check("rst_last",  32'(out_last), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 4; v++) begin
      int cyc;
      halted = 1'b0;
      @(posedge clk); #1;
      rec_cnt = 0; done_cnt = 0; rowend_cnt = 0; mark_cnt = 0;
      hold_pending = 1'b0;
      flags_in = vecs[v].flags; stack_ptr = vecs[v].sp;
      exp_flags = vecs[v].flags; exp_sp = vecs[v].sp;
      out_ready = 1'b1;
      mon_en = 1'b1;
      if (vecs[v].use_start) start = 1'b1; else halted = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check($sformatf("v%0d_lat0", v), {30'b0, busy, out_valid}, 32'b10);
      flags_in = ~vecs[v].flags; stack_ptr = ~vecs[v].sp;
      @(posedge clk); #1;
      check($sformatf("v%0d_lat1", v), 32'(out_valid), 32'd1);
      cyc = 0;
      while (busy && cyc < 4000) begin
        if (vecs[v].rnd_ready) out_ready = 1'($urandom_range(0, 1));
        if (vecs[v].disturb) begin
          if (cyc == 50) start = 1'b1;
          if (cyc == 51) start = 1'b0;
          if (cyc == 60) halted = ~halted;
          if (cyc == 70) halted = 1'b1;
          if (cyc == 400) start = 1'b1;
          if (cyc == 401) start = 1'b0;
        end
        @(posedge clk); #1;
        cyc++;
      end
      check($sformatf("v%0d_timeout", v), 32'(busy), 32'd0);
      out_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check($sformatf("v%0d_no_restart", v), 32'(busy), 32'd0);
      mon_en = 1'b0;
      check($sformatf("v%0d_records", v), 32'(rec_cnt), 32'd262);
      check($sformatf("v%0d_done", v), 32'(done_cnt), 32'd1);
      check($sformatf("v%0d_rowend", v), 32'(rowend_cnt), 32'd16);
      check($sformatf("v%0d_marks", v), 32'(mark_cnt), 32'd1);
    end

    // Reset mid-dump, then halted held across reset must not auto-trigger
    begin
      int cyc, dn;
      halted = 1'b0;
      @(posedge clk); #1;
      rec_cnt = 0; done_cnt = 0; rowend_cnt = 0; mark_cnt = 0; hold_pending = 1'b0;
      flags_in = 4'h3; stack_ptr = 8'h10; exp_flags = 4'h3; exp_sp = 8'h10;
      mon_en = 1'b1;
      halted = 1'b1;
      cyc = 0;
      while (rec_cnt < 100 && cyc < 2000) begin
        @(posedge clk); #1;
        cyc++;
      end
      check("rst_mid_reach100", 32'(rec_cnt >= 100), 32'd1);
      mon_en = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      check("rst_mid_valid", 32'(out_valid), 32'd0);
      check("rst_mid_busy",  32'(busy), 32'd0);
      reset = 1'b0;
      dn = 0;
      for (int i = 0; i < 6; i++) begin
        if (done || busy) dn++;
        @(posedge clk); #1;
      end
      check("rst_no_autodump", 32'(dn), 32'd0);
      halted = 1'b0;
      @(posedge clk); #1;
      halted = 1'b1;
      @(posedge clk); #1;
      check("rehalt_triggers", 32'(busy), 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
